// File: rtl/stream_xor_consumer.sv
// Stream cipher consumer: requests one keystream block per ciphertext word and emits
// plaintext = ciphertext XOR keystream, with a bounded wait on the keystream generator.
module stream_xor_consumer #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned KS_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  output logic                  ks_req,
  input  logic                  ks_done,
  input  logic [DATA_WIDTH-1:0] ks_block,
  input  logic                  ct_valid,
  output logic                  ct_ready,
  input  logic [DATA_WIDTH-1:0] ct_data,
  output logic                  pt_valid,
  input  logic                  pt_ready,
  output logic [DATA_WIDTH-1:0] pt_data,
  output logic [15:0]           block_count,
  output logic                  ks_error
);

  localparam int unsigned CntW = $clog2(KS_TIMEOUT + 1);

  typedef enum logic [2:0] {StIdle, StReq, StWaitKs, StReady, StOut} state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         wait_cnt_q;
  logic [DATA_WIDTH-1:0]   key_q;
  logic [DATA_WIDTH-1:0]   pt_data_q;
  logic [15:0]             block_cnt_q;
  logic                    ks_error_q;

  logic ks_accept, ks_timeout, ct_xfer, pt_xfer;

  // A zero wait count marks the first WAIT_KS cycle, where ks_done may still describe
  // the previous block and must not be trusted.
  assign ks_accept  = (state_q == StWaitKs) && (wait_cnt_q != '0) && ks_done;
  assign ks_timeout = (state_q == StWaitKs) && !ks_accept &&
                      (wait_cnt_q == CntW'(KS_TIMEOUT - 1));
  assign ct_xfer    = (state_q == StReady) && ct_valid;
  assign pt_xfer    = (state_q == StOut) && pt_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (en && !ks_error_q) state_d = StReq;
      StReq:    state_d = StWaitKs;
      StWaitKs: begin
        if (ks_accept) begin
          state_d = StReady;
        end else if (ks_timeout) begin
          state_d = StIdle;
        end
      end
      StReady:  if (ct_valid) state_d = StOut;
      StOut:    if (pt_ready) state_d = en ? StReq : StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    ks_req   = (state_q == StReq);
    ct_ready = (state_q == StReady);
    pt_valid = (state_q == StOut);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_q  <= '0;
      key_q       <= '0;
      pt_data_q   <= '0;
      block_cnt_q <= '0;
      ks_error_q  <= 1'b0;
    end else begin
      if (state_q == StReq) begin
        wait_cnt_q <= '0;
      end else if (state_q == StWaitKs) begin
        wait_cnt_q <= wait_cnt_q + CntW'(1);
      end
      if (ks_accept) key_q <= ks_block;
      if (ct_xfer) pt_data_q <= ct_data ^ key_q;
      if (pt_xfer) block_cnt_q <= block_cnt_q + 16'd1;
      if (ks_timeout) ks_error_q <= 1'b1;
    end
  end

  assign pt_data     = pt_data_q;
  assign block_count = block_cnt_q;
  assign ks_error    = ks_error_q;

endmodule

// File: doc/stream_xor_consumer.md
STREAM_XOR_CONSUMER -- requirements
Module: stream_xor_consumer

Interface
REQ-001 Parameter DATA_WIDTH, default 64, the width of keystream block, ciphertext word and plaintext word.
REQ-002 Parameter KS_TIMEOUT, default 255, the maximum cycles spent waiting for a keystream block.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 en  input  1  high permits a new keystream request from IDLE.
REQ-006 ks_req  output  1  one-cycle pulse that restarts the keystream generator for a fresh block.
REQ-007 ks_done  input  1  level from generator; high means ks_block holds a complete block.
REQ-008 ks_block  input  DATA_WIDTH  keystream block from generator.
REQ-009 ct_valid / ct_ready  input / output  1 each  ciphertext handshake; transfer when both high at a rising edge.
REQ-010 ct_data  input  DATA_WIDTH  ciphertext word.
REQ-011 pt_valid / pt_ready  output / input  1 each  plaintext handshake; transfer when both high at a rising edge.
REQ-012 pt_data  output  DATA_WIDTH  plaintext word, registered.
REQ-013 block_count  output  16  number of completed plaintext transfers.
REQ-014 ks_error  output  1  sticky keystream-timeout flag.

Function
REQ-015 The FSM SHALL have states IDLE, REQ, WAIT_KS, READY, OUT.
REQ-016 IDLE: all handshake outputs low; go to REQ when en=1 and ks_error=0.
REQ-017 REQ: ks_req=1 for exactly this cycle; wait counter cleared; go to WAIT_KS unconditionally.
REQ-018 WAIT_KS: ks_done SHALL be ignored in the first WAIT_KS cycle (stale-block guard); from the second cycle on, ks_done=1 latches ks_block into the internal key register and moves to READY.
REQ-019 WAIT_KS: wait counter increments each cycle; on reaching KS_TIMEOUT without an accepted ks_done, ks_error is set and FSM returns to IDLE.
REQ-020 READY: ct_ready=1; on ct_valid=1, pt_data <= ct_data XOR key register, pt_valid <= 1, go to OUT; otherwise hold.
REQ-021 OUT: pt_valid=1, pt_data stable, ct_ready=0 until pt_ready=1; on transfer pt_valid <= 0, block_count increments, go to REQ if en=1, else IDLE.
REQ-022 Each keystream block SHALL be used for exactly one ciphertext word; no reuse, no skipping.
REQ-023 Latency: ciphertext accept to pt_valid high = 1 cycle; pt transfer to next ks_req = 1 cycle.
REQ-024 block_count SHALL wrap from 16'hFFFF to 16'h0000 without flagging.
REQ-025 en falling mid-operation SHALL NOT abort a block in progress; it only prevents the next request.
REQ-026 ks_done toggling in READY or OUT SHALL be ignored; key register changes only in WAIT_KS.
REQ-027 ks_error SHALL remain set until reset; while set FSM stays in IDLE.

Reset
REQ-028 While rst=0: FSM=IDLE, ks_req=0, ct_ready=0, pt_valid=0, pt_data=0, key register=0, block_count=0, ks_error=0, wait counter=0.
REQ-029 Reset assertion mid-block SHALL discard the block immediately; first ks_req after release occurs no earlier than the second rising edge after rst=1 with en=1.

Verification
REQ-030 Basic: en=1, ks_block=64'hFFFF0000FFFF0000 with ks_done, ct_data=64'h0123456789ABCDEF -> pt_data=64'hFEDC45677654CDEF, block_count=1.
REQ-031 Backpressure: pt_ready=0 for 10 cycles -> pt_valid and pt_data stable, ct_ready=0, no ks_req until transfer.
REQ-032 Stale guard: ks_done held high through REQ and first WAIT_KS cycle with block A, then block B -> B used, A discarded.
REQ-033 Timeout: ks_done never asserted -> ks_error=1 exactly KS_TIMEOUT cycles into WAIT_KS, FSM IDLE, no further ks_req.
REQ-034 Wrap: preload via 65536 transfers (or forced) -> block_count 16'hFFFF then 16'h0000.
REQ-035 Reset mid-OUT: rst=0 while pt_valid=1 -> pt_valid=0, block_count=0 same cycle, fresh ks_req after release.
